spi_burst_mem_slave: RTL and testbench

// - SPI slave and on-chip memory in one block; successor to the 8-bit SPI/RAM pair.
// - Adds: independent ADDR_W/DATA_W, separate write/read pointers, auto-increment bursts,

---
 rtl/spi_burst_mem_slave_pkg.sv | 30 +++
 rtl/spi_burst_mem_slave_if.sv | 13 +
 rtl/spi_burst_mem_slave_ram.sv | 24 ++
 rtl/spi_burst_mem_slave.sv | 177 +++++++++++++++++
 tb/tb_spi_burst_mem_slave.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_burst_mem_slave_pkg.sv
// Shared opcodes, FSM states and status bit positions for the SPI burst memory slave.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_mem_pkg;

  localparam logic [2:0] OP_WR_ADDR   = 3'b000;
  localparam logic [2:0] OP_WR_DATA   = 3'b001;
  localparam logic [2:0] OP_RD_ADDR   = 3'b010;
  localparam logic [2:0] OP_RD_DATA   = 3'b011;
  localparam logic [2:0] OP_RD_STATUS = 3'b100;

  localparam int ST_WWRAP = 0;
  localparam int ST_RWRAP = 1;
  localparam int ST_BADOP = 2;
  localparam int ST_ABORT = 3;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, TURN, RDATA, STAT, DROP
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Opcodes 101..111 are undefined and send the frame to DROP.
  function automatic logic op_known(input logic [2:0] op);
    return (op <= OP_RD_STATUS);
  endfunction

endpackage

// File: rtl/spi_burst_mem_slave_if.sv
// SPI pin bundle between a master and the burst memory slave.
// Latency: n/a (wires only).
// Backpressure: none; SS_n framing is the only flow control on the link.
interface spi_burst_mem_slave_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic miso_oe;
  logic busy;

  modport slave  (input SS_n, MOSI, output MISO, miso_oe, busy);
  modport master (output SS_n, MOSI, input MISO, miso_oe, busy);
endinterface

// File: rtl/spi_burst_mem_slave_ram.sv
// Simple dual-port word memory: one write port, one synchronous read port.
// Latency: write lands on the enabled edge; read data is valid one edge after the address.
// Backpressure: none; both ports accept an access every cycle.
module spi_mem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Storage is never reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/spi_burst_mem_slave.sv
// SPI mode-0 slave fronting an on-chip memory: address/data bursts, streamed reads, sticky status.
// Latency: write lands one edge after its last bit; read MSB on MISO from payload edge 2 (edge 5).
// Backpressure: none; reads prefetch the next word so the stream never stalls.
module spi_burst_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_burst_mem_slave_if.slave spi
);

  localparam int MAX_W = max_int(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam logic [CNT_W-1:0]  CNT_OP2   = CNT_W'(2);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  DATA_DONE = CNT_W'(DATA_W);
  localparam logic [ADDR_W-1:0] PTR_STEP  = ADDR_W'(AUTO_INC);
  localparam logic [ADDR_W-1:0] PTR_MAX   = '1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_hi;
  logic [MAX_W-2:0]  sh_in;
  logic [MAX_W-1:0]  word_in;
  logic [DATA_W-1:0] sh_out;
  logic [DATA_W-1:0] stat_word;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [3:0]        status;
  logic [3:0]        st_set;
  logic              st_clr;
  logic              wr_pend;
  logic [DATA_W-1:0] wr_dat;
  logic [DATA_W-1:0] ram_q;

  assign word_in   = {sh_in, spi.MOSI};
  assign stat_word = DATA_W'(status);

  // Read port always follows rptr, so the word after the one being shifted is already fetched.
  spi_mem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_pend),
    .wr_addr (wptr),
    .wr_dat  (wr_dat),
    .rd_addr (rptr),
    .rd_dat  (ram_q)
  );

  // Status events for this edge; a set on the clearing edge survives the clear.
  always_comb begin
    st_set = '0;
    st_clr = 1'b0;
    if (!spi.SS_n) begin
      if (state == CMD && cnt == CNT_OP2 && !op_known({op_hi, spi.MOSI})) st_set[ST_BADOP] = 1'b1;
      if (state == RDATA && cnt == '0 && AUTO_INC && rptr == PTR_MAX) st_set[ST_RWRAP] = 1'b1;
      if (state == STAT && cnt == DATA_DONE) st_clr = 1'b1;
    end else begin
      if (state == CMD || ((state == ADDR || state == WDATA) && cnt != '0)) st_set[ST_ABORT] = 1'b1;
    end
    if (wr_pend && AUTO_INC && wptr == PTR_MAX) st_set[ST_WWRAP] = 1'b1;
  end

  // Frame FSM with registered pin outputs, pointers and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_hi    <= '0;
      sh_in    <= '0;
      sh_out   <= '0;
      wptr     <= '0;
      rptr     <= '0;
      status   <= '0;
      wr_pend  <= 1'b0;
      wr_dat   <= '0;
      spi.MISO    <= 1'b0;
      spi.miso_oe <= 1'b0;
      spi.busy    <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      status  <= (st_clr ? 4'b0 : status) | st_set;
      // The write queued on the previous edge commits now, even if SS_n has just risen.
      if (wr_pend) wptr <= wptr + PTR_STEP;
      spi.MISO    <= 1'b0;
      spi.miso_oe <= 1'b0;
      if (spi.SS_n) begin
        state    <= IDLE;
        cnt      <= '0;
        spi.busy <= 1'b0;
      end else begin
        spi.busy <= 1'b1;
        unique case (state)
          IDLE: begin
            state <= CMD;
            op_hi <= {1'b0, spi.MOSI};
            cnt   <= CNT_W'(1);
          end
          CMD: begin
            if (cnt != CNT_OP2) begin
              op_hi <= {op_hi[0], spi.MOSI};
              cnt   <= CNT_OP2;
            end else begin
              cnt <= '0;
              case ({op_hi, spi.MOSI})
                OP_WR_ADDR, OP_RD_ADDR: state <= ADDR;
                OP_WR_DATA:             state <= WDATA;
                OP_RD_DATA:             state <= TURN;
                OP_RD_STATUS:           state <= STAT;
                default:                state <= DROP;
              endcase
            end
          end
          ADDR: begin
            sh_in <= word_in[MAX_W-2:0];
            if (cnt == ADDR_LAST) begin
              // op_hi keeps opcode bits [2:1]; bit 1 separates RD_ADDR from WR_ADDR.
              if (op_hi[0]) rptr <= word_in[ADDR_W-1:0];
              else          wptr <= word_in[ADDR_W-1:0];
              state <= DROP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          WDATA: begin
            sh_in <= word_in[MAX_W-2:0];
            if (cnt == DATA_LAST) begin
              wr_pend <= 1'b1;
              wr_dat  <= word_in[DATA_W-1:0];
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          TURN: state <= RDATA;
          RDATA: begin
            spi.miso_oe <= 1'b1;
            if (cnt == '0) begin
              spi.MISO <= ram_q[DATA_W-1];
              sh_out   <= {ram_q[DATA_W-2:0], 1'b0};
              rptr     <= rptr + PTR_STEP;
              cnt      <= CNT_W'(1);
            end else begin
              spi.MISO <= sh_out[DATA_W-1];
              sh_out   <= sh_out << 1;
              cnt      <= (cnt == DATA_LAST) ? '0 : cnt + CNT_W'(1);
            end
          end
          STAT: begin
            if (cnt == DATA_DONE) begin
              state <= DROP;
              cnt   <= '0;
            end else begin
              spi.miso_oe <= 1'b1;
              if (cnt == '0) begin
                spi.MISO <= stat_word[DATA_W-1];
                sh_out   <= {stat_word[DATA_W-2:0], 1'b0};
              end else begin
                spi.MISO <= sh_out[DATA_W-1];
                sh_out   <= sh_out << 1;
              end
              cnt <= cnt + CNT_W'(1);
            end
          end
          DROP: state <= DROP;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_mem_slave.sv
// Directed bench for the SPI burst memory slave against a frame-level memory/pointer model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_spi_burst_mem_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_burst_mem_slave_if bus();

  spi_burst_mem_slave #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (bus)
  );

  int errors;
  int checks;

  // Frame-level model of the slave's architectural state.
  logic [7:0] m_mem [256];
  int         m_wptr;
  int         m_rptr;
  logic [7:0] m_status;

  // Per-edge pin expectations, consumed by the compare process.
  logic e_miso, e_oe, e_busy;
  bit   chk_en;

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: pins after every driven edge, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("miso",    64'(bus.MISO),    64'(e_miso));
      check1("miso_oe", 64'(bus.miso_oe), 64'(e_oe));
      check1("busy",    64'(bus.busy),    64'(e_busy));
    end
  end

  task automatic step(input logic ss, input logic mosi, input logic em, input logic eo, input logic eb);
    bus.SS_n = ss;
    bus.MOSI = mosi;
    @(posedge clk);
    #1;
    e_miso = em;
    e_oe   = eo;
    e_busy = eb;
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  // Sends bits[nb-1] first; returns the MISO bits seen while miso_oe is expected high.
  task automatic frame(input logic [79:0] bits, input int nb, input bit rst_end, output logic [63:0] rx);
    logic [2:0] opc;
    logic [7:0] st_snap;
    logic [7:0] w;
    int         r0;
    int         p;
    int         loads;
    logic       em;
    logic       eo;
    opc     = 3'b000;
    if (nb >= 3) opc = bits[nb-1 -: 3];
    p       = nb - 3;
    st_snap = m_status;
    r0      = m_rptr;
    rx      = '0;
    for (int k = 1; k <= nb; k++) begin
      em = 1'b0;
      eo = 1'b0;
      if (nb >= 3 && opc == 3'b011 && k >= 5) begin
        w  = m_mem[(r0 + (k - 5) / 8) % 256];
        em = w[7 - ((k - 5) % 8)];
        eo = 1'b1;
      end
      if (nb >= 3 && opc == 3'b100 && k >= 4 && k <= 11) begin
        em = st_snap[7 - (k - 4)];
        eo = 1'b1;
      end
      step(1'b0, bits[nb-k], em, eo, 1'b1);
      if (eo) rx = {rx[62:0], bus.MISO};
    end
    if (rst_end) begin
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check1("rst_async_miso",    64'(bus.MISO),    64'h0);
      check1("rst_async_miso_oe", 64'(bus.miso_oe), 64'h0);
      check1("rst_async_busy",    64'(bus.busy),    64'h0);
      bus.SS_n = 1'b1;
      m_wptr   = 0;
      m_rptr   = 0;
      m_status = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end else begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (nb < 3) begin
        if (nb > 0) m_status[3] = 1'b1;
      end else begin
        case (opc)
          3'b000, 3'b010: begin
            if (p > 0 && p < 8) m_status[3] = 1'b1;
            else if (p >= 8) begin
              if (opc == 3'b000) m_wptr = int'(bits[p-1 -: 8]);
              else               m_rptr = int'(bits[p-1 -: 8]);
            end
          end
          3'b001: begin
            for (int i = 0; i < p / 8; i++) begin
              m_mem[m_wptr] = bits[p-1-8*i -: 8];
              if (m_wptr == 255) m_status[0] = 1'b1;
              m_wptr = (m_wptr + 1) % 256;
            end
            if (p % 8 != 0) m_status[3] = 1'b1;
          end
          3'b011: begin
            loads = (nb >= 5) ? (nb - 5) / 8 + 1 : 0;
            for (int i = 0; i < loads; i++) begin
              if (m_rptr == 255) m_status[1] = 1'b1;
              m_rptr = (m_rptr + 1) % 256;
            end
          end
          3'b100: if (nb >= 12) m_status = '0;
          default: m_status[2] = 1'b1;
        endcase
      end
    end
  endtask

  logic [63:0] rx;

  initial begin
    errors   = 0;
    checks   = 0;
    chk_en   = 1'b0;
    e_miso   = 1'b0;
    e_oe     = 1'b0;
    e_busy   = 1'b0;
    m_wptr   = 0;
    m_rptr   = 0;
    m_status = '0;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset_miso",    64'(bus.MISO),    64'h0);
    check1("reset_miso_oe", 64'(bus.miso_oe), 64'h0);
    check1("reset_busy",    64'(bus.busy),    64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    frame(80'({3'b100, 9'h0}), 12, 1'b0, rx);
    check1("status_after_reset", 64'(rx[7:0]), 64'h00);

    // Burst write then gapless burst read.
    frame(80'({3'b000, 8'h10}), 11, 1'b0, rx);
    frame(80'({3'b001, 8'hA5, 8'h5A}), 19, 1'b0, rx);
    frame(80'({3'b010, 8'h10}), 11, 1'b0, rx);
    frame(80'({3'b011, 17'h0}), 20, 1'b0, rx);
    check1("burst_read_a5_5a", 64'(rx[15:0]), 64'hA55A);

    // Write pointer wrap from 0xFF to 0x00.
    frame(80'({3'b000, 8'hFF}), 11, 1'b0, rx);
    frame(80'({3'b001, 8'h11, 8'h22}), 19, 1'b0, rx);
    frame(80'({3'b100, 9'h0}), 12, 1'b0, rx);
    check1("status_wwrap", 64'(rx[7:0]), 64'h01);
    frame(80'({3'b100, 9'h0}), 12, 1'b0, rx);
    check1("status_cleared", 64'(rx[7:0]), 64'h00);

    // Read pointer wrap across the top of memory.
    frame(80'({3'b010, 8'hFF}), 11, 1'b0, rx);
    frame(80'({3'b011, 17'h0}), 20, 1'b0, rx);
    check1("wrap_read_11_22", 64'(rx[15:0]), 64'h1122);
    frame(80'({3'b100, 9'h0}), 12, 1'b0, rx);
    check1("status_rwrap", 64'(rx[7:0]), 64'h02);

    // Aborted write leaves memory and wptr untouched.
    frame(80'({3'b000, 8'h20}), 11, 1'b0, rx);
    frame(80'({3'b001, 8'h3C}), 11, 1'b0, rx);
    frame(80'({3'b000, 8'h20}), 11, 1'b0, rx);
    frame(80'({3'b001, 5'b10110}), 8, 1'b0, rx);
    frame(80'({3'b100, 9'h0}), 12, 1'b0, rx);
    check1("status_abort", 64'(rx[7:0]), 64'h08);
    frame(80'({3'b010, 8'h20}), 11, 1'b0, rx);
    frame(80'({3'b011, 9'h0}), 12, 1'b0, rx);
    check1("abort_mem_kept", 64'(rx[7:0]), 64'h3C);
    frame(80'({3'b001, 8'h77}), 11, 1'b0, rx);
    frame(80'({3'b010, 8'h20}), 11, 1'b0, rx);
    frame(80'({3'b011, 9'h0}), 12, 1'b0, rx);
    check1("abort_wptr_kept", 64'(rx[7:0]), 64'h77);

    // Undefined opcode with trailing bits.
    frame(80'({3'b111, 16'hBEEF}), 19, 1'b0, rx);
    frame(80'({3'b100, 9'h0}), 12, 1'b0, rx);
    check1("status_badop", 64'(rx[7:0]), 64'h04);

    // Frame ended inside the opcode.
    frame(80'(2'b01), 2, 1'b0, rx);
    frame(80'({3'b100, 9'h0}), 12, 1'b0, rx);
    check1("status_cmd_abort", 64'(rx[7:0]), 64'h08);

    // Reset in the middle of a read burst, then read from address 0.
    frame(80'({3'b010, 8'h10}), 11, 1'b0, rx);
    frame(80'({3'b011, 7'h0}), 10, 1'b1, rx);
    check1("partial_before_reset", 64'(rx[5:0]), 64'h29);
    frame(80'({3'b011, 9'h0}), 12, 1'b0, rx);
    check1("read_after_reset", 64'(rx[7:0]), 64'h22);
    frame(80'({3'b100, 9'h0}), 12, 1'b0, rx);
    check1("status_after_midreset", 64'(rx[7:0]), 64'h00);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
